// File: rtl/regfile_flag_unit_pkg.sv
// Shared opcode, condition-code and flag-position definitions for the
// register/flag stage and the ALU.
package regfile_flag_unit_pkg;

    typedef enum logic [2:0] {
        ADD    = 3'b000,
        SUB    = 3'b001,
        RED    = 3'b010,
        XOR    = 3'b011,
        SLL    = 3'b100,
        SRA    = 3'b101,
        ROR    = 3'b110,
        PADDSB = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        NE     = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GTE    = 3'b100,
        LTE    = 3'b101,
        OVFL   = 3'b110,
        UNCOND = 3'b111
    } cond_e;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/regfile_flag_unit_reg16_async_rst.sv
// Single storage register with load enable and asynchronous active-high clear.
module reg16_async_rst #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Clear immediately on reset, otherwise load when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/regfile_flag_unit.sv
// Register file with write-before-read bypass, N/V/Z flag register with
// opcode-selective update, and branch condition evaluation on latched flags.
module regfile_flag_unit
    import regfile_flag_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 16,
    localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  SrcReg1,
    input  logic [IDX_W-1:0]  SrcReg2,
    input  logic [IDX_W-1:0]  DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    input  logic              FlagWrite,
    input  logic [2:0]        AluOp,
    input  logic [2:0]        FlagsIn,
    output logic [2:0]        Flags,
    input  logic [2:0]        Cond,
    output logic              CondTrue
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_valid;
    logic [2:0]        flags_q;
    logic [2:0]        flags_d;

    // R0 is hard-wired to zero, so a write to index 0 never counts as a write.
    assign wr_valid = WriteReg && (DstReg != '0);
    assign regs[0]  = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            reg16_async_rst #(
                .W(DATA_W)
            ) u_reg (
                .clk  (clk),
                .rst  (rst),
                .en_i (wr_valid && (DstReg == IDX_W'(gi))),
                .d_i  (DstData),
                .q_o  (regs[gi])
            );
        end
    endgenerate

    // Read ports: stored value, overridden by same-cycle write data.
    always_comb begin
        SrcData1 = regs[SrcReg1];
        SrcData2 = regs[SrcReg2];
        if (wr_valid && (DstReg == SrcReg1)) begin
            SrcData1 = DstData;
        end
        if (wr_valid && (DstReg == SrcReg2)) begin
            SrcData2 = DstData;
        end
    end

    // Next flags: ADD/SUB load all, logic/shift ops load only Z, others hold.
    always_comb begin
        flags_d = flags_q;
        if (FlagWrite) begin
            case (AluOp)
                ADD, SUB: flags_d = FlagsIn;
                XOR, SLL, SRA, ROR: flags_d[FLAG_Z] = FlagsIn[FLAG_Z];
                default: flags_d = flags_q;
            endcase
        end
    end

    // Flag register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flags = flags_q;

    // Branch condition from the latched flags only (no FlagsIn bypass).
    always_comb begin
        CondTrue = 1'b0;
        case (Cond)
            NE:      CondTrue = !flags_q[FLAG_Z];
            EQ:      CondTrue = flags_q[FLAG_Z];
            GT:      CondTrue = !flags_q[FLAG_Z] && !flags_q[FLAG_N];
            LT:      CondTrue = flags_q[FLAG_N];
            GTE:     CondTrue = flags_q[FLAG_Z] || (!flags_q[FLAG_Z] && !flags_q[FLAG_N]);
            LTE:     CondTrue = flags_q[FLAG_N] || flags_q[FLAG_Z];
            OVFL:    CondTrue = flags_q[FLAG_V];
            UNCOND:  CondTrue = 1'b1;
            default: CondTrue = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_regfile_flag_unit.sv
// Directed bench for regfile_flag_unit: vector table plus reset, condition
// sweep and flag-timing sequences.
module tb_regfile_flag_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  SrcReg1, SrcReg2, DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] SrcData1, SrcData2;
    logic        FlagWrite;
    logic [2:0]  AluOp, FlagsIn, Flags, Cond;
    logic        CondTrue;

    int unsigned n_pass;
    int unsigned n_total;

    regfile_flag_unit #(
        .NUM_REGS(16),
        .DATA_W  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2),
        .FlagWrite(FlagWrite),
        .AluOp    (AluOp),
        .FlagsIn  (FlagsIn),
        .Flags    (Flags),
        .Cond     (Cond),
        .CondTrue (CondTrue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [3:0]  dst;
        logic        we;
        logic [15:0] dd;
        logic        fw;
        logic [2:0]  op;
        logic [2:0]  fin;
        logic [2:0]  cond;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [2:0]  ef;
        logic        ect;
    } vec_t;

    vec_t tbl [17];

    // CondTrue truth table per condition code; bit index is {N,V,Z}.
    logic [7:0] cond_mask [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_idle();
        SrcReg1   = 4'd0;
        SrcReg2   = 4'd0;
        DstReg    = 4'd0;
        WriteReg  = 1'b0;
        DstData   = 16'h0000;
        FlagWrite = 1'b0;
        AluOp     = 3'b000;
        FlagsIn   = 3'b000;
        Cond      = 3'b000;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        cond_mask[0] = 8'h55; // NE
        cond_mask[1] = 8'hAA; // EQ
        cond_mask[2] = 8'h05; // GT
        cond_mask[3] = 8'hF0; // LT
        cond_mask[4] = 8'hAF; // GTE
        cond_mask[5] = 8'hFA; // LTE
        cond_mask[6] = 8'hCC; // OVFL
        cond_mask[7] = 8'hFF; // UNCOND

        //            sr1 sr2 dst we dd         fw op    fin   cond   e1         e2         ef    ect
        tbl[0]  = '{4'd5, 4'd0, 4'd5, 1, 16'hBEEF, 0, 3'd0, 3'b000, 3'd0, 16'hBEEF, 16'h0000, 3'b000, 1};
        tbl[1]  = '{4'd5, 4'd5, 4'd0, 0, 16'h0000, 0, 3'd0, 3'b000, 3'd2, 16'hBEEF, 16'hBEEF, 3'b000, 1};
        tbl[2]  = '{4'd0, 4'd0, 4'd0, 1, 16'h1234, 0, 3'd0, 3'b000, 3'd5, 16'h0000, 16'h0000, 3'b000, 0};
        tbl[3]  = '{4'd0, 4'd0, 4'd0, 0, 16'h0000, 0, 3'd0, 3'b000, 3'd1, 16'h0000, 16'h0000, 3'b000, 0};
        tbl[4]  = '{4'd3, 4'd5, 4'd3, 1, 16'h0001, 0, 3'd0, 3'b000, 3'd7, 16'h0001, 16'hBEEF, 3'b000, 1};
        tbl[5]  = '{4'd3, 4'd3, 4'd3, 1, 16'hA5A5, 0, 3'd0, 3'b000, 3'd6, 16'hA5A5, 16'hA5A5, 3'b000, 0};
        tbl[6]  = '{4'd3, 4'd3, 4'd0, 0, 16'h0000, 0, 3'd0, 3'b000, 3'd3, 16'hA5A5, 16'hA5A5, 3'b000, 0};
        tbl[7]  = '{4'd7, 4'd4, 4'd7, 1, 16'h7777, 1, 3'd0, 3'b110, 3'd4, 16'h7777, 16'h0000, 3'b000, 1};
        tbl[8]  = '{4'd7, 4'd3, 4'd0, 0, 16'h0000, 1, 3'd3, 3'b001, 3'd3, 16'h7777, 16'hA5A5, 3'b110, 1};
        tbl[9]  = '{4'd0, 4'd0, 4'd0, 0, 16'h0000, 1, 3'd7, 3'b000, 3'd1, 16'h0000, 16'h0000, 3'b111, 1};
        tbl[10] = '{4'd0, 4'd0, 4'd0, 0, 16'h0000, 0, 3'd0, 3'b000, 3'd2, 16'h0000, 16'h0000, 3'b111, 0};
        tbl[11] = '{4'd0, 4'd0, 4'd0, 0, 16'h0000, 1, 3'd4, 3'b000, 3'd6, 16'h0000, 16'h0000, 3'b111, 1};
        tbl[12] = '{4'd0, 4'd0, 4'd0, 0, 16'h0000, 1, 3'd2, 3'b111, 3'd0, 16'h0000, 16'h0000, 3'b110, 1};
        tbl[13] = '{4'd15, 4'd0, 4'd15, 1, 16'hFFFF, 1, 3'd1, 3'b001, 3'd5, 16'hFFFF, 16'h0000, 3'b110, 1};
        tbl[14] = '{4'd15, 4'd7, 4'd0, 0, 16'h0000, 0, 3'd0, 3'b000, 3'd1, 16'hFFFF, 16'h7777, 3'b001, 1};
        tbl[15] = '{4'd5, 4'd5, 4'd5, 0, 16'h0000, 0, 3'd0, 3'b000, 3'd2, 16'hBEEF, 16'hBEEF, 3'b001, 0};
        tbl[16] = '{4'd5, 4'd3, 4'd0, 0, 16'h0000, 0, 3'd0, 3'b000, 3'd4, 16'hBEEF, 16'hA5A5, 3'b001, 1};

        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        SrcReg1 = 4'd9;
        SrcReg2 = 4'd15;
        #1;
        chk("reset_rd1", 32'(SrcData1), 32'h0000);
        chk("reset_rd2", 32'(SrcData2), 32'h0000);
        chk("reset_flags", 32'(Flags), 32'h0);

        // Vector table: inputs applied at negedge, outputs checked before next posedge.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            SrcReg1   = tbl[i].sr1;
            SrcReg2   = tbl[i].sr2;
            DstReg    = tbl[i].dst;
            WriteReg  = tbl[i].we;
            DstData   = tbl[i].dd;
            FlagWrite = tbl[i].fw;
            AluOp     = tbl[i].op;
            FlagsIn   = tbl[i].fin;
            Cond      = tbl[i].cond;
            #1;
            chk($sformatf("v%0d_rd1", i), 32'(SrcData1), 32'(tbl[i].e1));
            chk($sformatf("v%0d_rd2", i), 32'(SrcData2), 32'(tbl[i].e2));
            chk($sformatf("v%0d_flags", i), 32'(Flags), 32'(tbl[i].ef));
            chk($sformatf("v%0d_cond", i), 32'(CondTrue), 32'(tbl[i].ect));
        end

        // Asynchronous reset mid-cycle: R5 (BEEF) and flags (001) clear at once.
        @(negedge clk);
        drive_idle();
        SrcReg1 = 4'd5;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_r5", 32'(SrcData1), 32'h0000);
        chk("async_rst_flags", 32'(Flags), 32'h0);
        // Writes and flag updates across an edge while reset is held are ignored.
        DstReg    = 4'd6;
        WriteReg  = 1'b1;
        DstData   = 16'h1111;
        FlagWrite = 1'b1;
        AluOp     = 3'b000;
        FlagsIn   = 3'b111;
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        SrcReg1 = 4'd6;
        SrcReg2 = 4'd3;
        #1;
        chk("rst_hold_r6", 32'(SrcData1), 32'h0000);
        chk("rst_hold_r3", 32'(SrcData2), 32'h0000);
        chk("rst_hold_flags", 32'(Flags), 32'h0);

        // Condition sweep: load all flags via ADD, then try all 8 codes.
        for (int f = 0; f < 8; f++) begin
            @(negedge clk);
            drive_idle();
            FlagWrite = 1'b1;
            AluOp     = 3'b000;
            FlagsIn   = 3'(f);
            @(negedge clk);
            drive_idle();
            #1;
            chk($sformatf("sweep_flags_%0d", f), 32'(Flags), 32'(f));
            for (int c = 0; c < 8; c++) begin
                logic [7:0] m;
                Cond = 3'(c);
                #1;
                m = cond_mask[c];
                chk($sformatf("cond_f%0d_c%0d", f, c), 32'(CondTrue), 32'(m[f]));
            end
        end

        // Flag timing: clear flags, then a SUB producing Z with an EQ branch in the same cycle.
        @(negedge clk);
        drive_idle();
        FlagWrite = 1'b1;
        AluOp     = 3'b000;
        FlagsIn   = 3'b000;
        @(negedge clk);
        FlagWrite = 1'b1;
        AluOp     = 3'b001;
        FlagsIn   = 3'b001;
        Cond      = 3'b001;
        #1;
        chk("timing_same_cycle", 32'(CondTrue), 32'h0);
        @(negedge clk);
        FlagWrite = 1'b0;
        FlagsIn   = 3'b000;
        #1;
        chk("timing_next_cycle", 32'(CondTrue), 32'h1);
        chk("timing_flags", 32'(Flags), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_flag_unit.md
Name: regfile_flag_unit

Overview:
- Architectural state stage around the ALU in the single-cycle datapath.
- Upstream of the ALU: holds the 16x16 register file and supplies both ALU operands.
- Downstream of the ALU: captures writeback data and latches the N/V/Z condition flags (Flags_out[2]=N, [1]=V, [0]=Z).
- Evaluates the 3-bit branch condition against the latched flags for the PC logic.

Parameters:
- NUM_REGS, 16, register count; register index width is log2(NUM_REGS).
- DATA_W, 16, register and datapath width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- SrcReg1  input  4  read port 1 index (feeds ALU_In1).
- SrcReg2  input  4  read port 2 index (feeds ALU_In2).
- DstReg  input  4  write port index.
- WriteReg  input  1  write enable for the register file.
- DstData  input  16  writeback data (ALU_Out or memory data, muxed outside).
- SrcData1  output  16  read data, port 1.
- SrcData2  output  16  read data, port 2.
- FlagWrite  input  1  current instruction is a flag-setting ALU op.
- AluOp  input  3  ALU opcode of the current instruction.
- FlagsIn  input  3  Flags_out from the ALU, {N,V,Z}.
- Flags  output  3  latched {N,V,Z}.
- Cond  input  3  branch condition code.
- CondTrue  output  1  branch condition satisfied by the latched flags.

Behaviour:
- Reset:
  - rst high clears all registers to 16'h0000 and Flags to 3'b000 immediately, with no wait for clk.
  - While rst is high, writes and flag updates are ignored.
  - On rst deassertion, state stays zero until the next qualified clk edge.
- Register 0:
  - Reads of R0 always return 16'h0000.
  - Writes to R0 are discarded, and no bypass occurs for index 0.
- Reads:
  - Combinational, zero latency.
  - Write-before-read bypass: if WriteReg=1, DstReg=SrcRegN and DstReg!=0, then SrcDataN=DstData in the same cycle.
  - Otherwise SrcDataN is the stored value.
  - Both ports may read the same index, and both bypass independently.
- Writes:
  - On the rising clk edge, if WriteReg=1 and DstReg!=0, then reg[DstReg] <= DstData.
  - The new value is visible as stored data from the next cycle.
- Flag update (rising clk edge, only when FlagWrite=1):
  - AluOp ADD(000) or SUB(001): N, V and Z all load from FlagsIn.
  - AluOp XOR(011), SLL(100), SRA(101) or ROR(110): only Z loads; N and V hold.
  - AluOp RED(010) or PADDSB(111): no flag changes.
  - FlagWrite=0: all flags hold.
- Flag output and branch timing:
  - Flags is the registered value only; there is no bypass from FlagsIn.
  - A branch therefore sees the flags of the last completed flag-setting instruction.
- CondTrue (combinational from latched flags):
  - 000 NE: Z==0.
  - 001 EQ: Z==1.
  - 010 GT: Z==0 and N==0.
  - 011 LT: N==1.
  - 100 GTE: Z==1 or (Z==0 and N==0).
  - 101 LTE: N==1 or Z==1.
  - 110 OVFL: V==1.
  - 111 UNCOND: always 1.
- Simultaneous events:
  - A register write and a flag update in the same cycle are independent; both take effect.
  - A write and a read of the same register in the same cycle returns the new data via the bypass.
- Unknown or undriven inputs are not defined behaviour; the bench drives all inputs every cycle.

Decomposition:
- Shared package holds:
  - ALU opcode constants ADD..PADDSB, shared with the ALU.
  - Condition code constants NE..UNCOND.
  - Flag bit positions FLAG_N=2, FLAG_V=1, FLAG_Z=0.
- One sub-module: reg16_async_rst.
  - A 16-bit register with write enable and asynchronous active-high reset.
  - Instantiated NUM_REGS-1 times; R0 needs no storage.
- The flag register and condition logic stay inline.

Test Plan:
- Reset: write R5=16'hBEEF, then assert rst mid-cycle between edges → SrcData1 for index 5 reads 16'h0000 immediately; Flags=3'b000.
- R0 protection: WriteReg=1, DstReg=0, DstData=16'h1234 → R0 reads 16'h0000 on both the same and the next cycle.
- Bypass: R3 holds 16'h0001; write R3=16'hA5A5 with SrcReg1=SrcReg2=3 → both SrcData read 16'hA5A5 in the same cycle, and 16'hA5A5 after the edge.
- Selective flags:
  - ADD with FlagsIn=3'b110 → Flags=3'b110.
  - Then XOR with FlagsIn=3'b001 → Flags=3'b111.
  - Then PADDSB with FlagsIn=3'b000 → Flags stays 3'b111.
- Conditions: sweep Flags {N,V,Z} through all 8 values × all 8 Cond codes.
  - Check CondTrue against the table, e.g. Flags=3'b000: GT=1, LTE=0.
  - Flags=3'b010: OVFL=1.
- Flag timing: flag-setting SUB producing Z=1, with Cond=EQ in the same cycle → CondTrue=0 in that cycle, 1 in the following cycle.
